// File: rtl/audio_pkg.sv
// Shared constants and helpers for the codec audio path (speaker and line-in).
package audio_pkg;

  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned BITS_PER_HALF = 16;
  localparam int unsigned CNT_W         = 9;

  // Counter bit positions that drive the codec clocks
  localparam int unsigned MCLK_BIT = 1;
  localparam int unsigned SCK_BIT  = 3;
  localparam int unsigned LRCK_BIT = 8;

  // Low counter nibble on the first cycle with sck high
  localparam logic [3:0] CAPTURE_PHASE = 4'd8;

  // Thermometer meter code: n ones (LSB-aligned), n = |s| >> 11, n in 0..16.
  // Magnitude is formed at 17 bits so -32768 negates without overflow.
  function automatic logic [SAMPLE_W-1:0] level_code(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W:0] ext;
    logic [SAMPLE_W:0] mag;
    logic [SAMPLE_W:0] n;
    logic [SAMPLE_W-1:0] code;
    ext  = {s[SAMPLE_W-1], s};
    mag  = s[SAMPLE_W-1] ? (~ext + 17'd1) : ext;
    n    = mag >> 11;
    code = '0;
    for (int unsigned i = 0; i < SAMPLE_W; i++) begin
      code[i] = (i < 32'(n));
    end
    return code;
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Codec clock generator: free-running 9-bit counter with registered
// mclk (clk/4), sck (clk/16) and lrck (clk/512). Exports the counter.
module audio_clk_gen
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             mclk,
  output logic             sck,
  output logic             lrck
);

  logic [CNT_W-1:0] cnt_nxt;

  // Next counter value; the clock outputs register from it so they track cnt
  always_comb begin
    cnt_nxt = cnt + 9'd1;
  end

  // Counter and clock output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      mclk <= 1'b0;
      sck  <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      mclk <= cnt_nxt[MCLK_BIT];
      sck  <= cnt_nxt[SCK_BIT];
      lrck <= cnt_nxt[LRCK_BIT];
    end
  end

endmodule

// File: rtl/line_in_ctrl.sv
// I2S line-in receiver: generates codec clocks and deserializes audio_sdout
// into coherent 16-bit left/right pairs with a one-cycle sample_valid strobe.
// Optional feature macro: LINE_IN_LEVEL_EN adds the level_led meter output.
module line_in_ctrl
  import audio_pkg::*;
#(
  parameter bit SWAP_LR = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  input  logic                audio_sdout,
  output logic [SAMPLE_W-1:0] audio_out_left,
  output logic [SAMPLE_W-1:0] audio_out_right,
  output logic                sample_valid
`ifdef LINE_IN_LEVEL_EN
  ,
  output logic [SAMPLE_W-1:0] level_led
`endif
);

  logic [CNT_W-1:0]    cnt;
  logic                sdout_q;
  logic [SAMPLE_W-1:0] shift16;
  logic [SAMPLE_W-1:0] left_hold;
  logic                primed;
  logic [4:0]          slot;
  logic                capture;
  logic [SAMPLE_W-1:0] shift_in;
  logic [SAMPLE_W-1:0] new_left;
  logic [SAMPLE_W-1:0] new_right;

  audio_clk_gen u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .mclk  (audio_mclk),
    .sck   (audio_sck),
    .lrck  (audio_lrck)
  );

  // Capture timing, shift input and (optionally swapped) output words
  always_comb begin
    slot      = cnt[8:4];
    capture   = (cnt[3:0] == CAPTURE_PHASE);
    shift_in  = {shift16[SAMPLE_W-2:0], sdout_q};
    new_left  = SWAP_LR ? shift_in  : left_hold;
    new_right = SWAP_LR ? left_hold : shift_in;
  end

  // Deserializer, left-word holding register and output pair update.
  // The right word completes at slot 0 of the next frame (I2S one-bit delay),
  // so the pair is published there, once a left word has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sdout_q         <= 1'b0;
      shift16         <= '0;
      left_hold       <= '0;
      primed          <= 1'b0;
      audio_out_left  <= '0;
      audio_out_right <= '0;
      sample_valid    <= 1'b0;
    end else begin
      sdout_q      <= audio_sdout;
      sample_valid <= 1'b0;
      if (capture) begin
        shift16 <= shift_in;
        if (slot == 5'(BITS_PER_HALF)) begin
          left_hold <= shift_in;
          primed    <= 1'b1;
        end
        if (slot == 5'd0 && primed) begin
          audio_out_left  <= new_left;
          audio_out_right <= new_right;
          sample_valid    <= 1'b1;
        end
      end
    end
  end

`ifdef LINE_IN_LEVEL_EN
  // Level meter follows the left word published with each strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      level_led <= '0;
    end else if (capture && slot == 5'd0 && primed) begin
      level_led <= level_code(new_left);
    end
  end
`endif

endmodule

// File: tb/tb_line_in_ctrl.sv
// Self-checking bench for line_in_ctrl: an I2S codec model drives randomized
// and directed frames; a frame-level reference model predicts every output.
module tb_line_in_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        audio_sdout = 1'b0;

  logic        mclk0, sck0, lrck0, valid0;
  logic [15:0] left0, right0;
  logic        mclk1, sck1, lrck1, valid1;
  logic [15:0] left1, right1;
`ifdef LINE_IN_LEVEL_EN
  logic [15:0] level0, level1;
`endif

  line_in_ctrl #(.SWAP_LR(1'b0)) dut (
    .clk             (clk),
    .reset           (reset),
    .audio_mclk      (mclk0),
    .audio_sck       (sck0),
    .audio_lrck      (lrck0),
    .audio_sdout     (audio_sdout),
    .audio_out_left  (left0),
    .audio_out_right (right0),
    .sample_valid    (valid0)
`ifdef LINE_IN_LEVEL_EN
    ,
    .level_led       (level0)
`endif
  );

  line_in_ctrl #(.SWAP_LR(1'b1)) dut_swap (
    .clk             (clk),
    .reset           (reset),
    .audio_mclk      (mclk1),
    .audio_sck       (sck1),
    .audio_lrck      (lrck1),
    .audio_sdout     (audio_sdout),
    .audio_out_left  (left1),
    .audio_out_right (right1),
    .sample_valid    (valid1)
`ifdef LINE_IN_LEVEL_EN
    ,
    .level_led       (level1)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] fl [16];
  logic [15:0] fr [16];
  int unsigned edges = 0;
  logic [15:0] exp_l = '0;
  logic [15:0] exp_r = '0;
  logic [15:0] exp_level = '0;
  int          sck_rise, lrck_rise, mclk_rise, pulses;
  logic        p_sck, p_lrck, p_mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] level_of(input logic [15:0] s);
    int a;
    int n;
    a = int'($signed(s));
    if (a < 0) a = -a;
    n = a / 2048;
    return 16'((33'h1 << n) - 33'h1);
  endfunction

  // One clock: advance the model, compare all outputs, drive the next bit
  task automatic tick();
    int unsigned c, b, f, fo;
    logic v;
    @(posedge clk);
    #1;
    if (reset) edges = 0;
    else edges++;
    v = !reset && edges >= 521 && ((edges - 1) % 512) == 8;
    if (reset) begin
      exp_l = '0;
      exp_r = '0;
      exp_level = '0;
    end else if (v) begin
      fo = (edges - 1) / 512 - 1;
      exp_l = fl[fo];
      exp_r = fr[fo];
      exp_level = level_of(fl[fo]);
    end
    c = edges % 512;
    check("valid", 32'(valid0), 32'(v));
    check("left", 32'(left0), 32'(exp_l));
    check("right", 32'(right0), 32'(exp_r));
    check("swap_valid", 32'(valid1), 32'(v));
    check("swap_left", 32'(left1), 32'(exp_r));
    check("swap_right", 32'(right1), 32'(exp_l));
    check("sck", 32'(sck0), (c >> 3) & 1);
    check("lrck", 32'(lrck0), (c >> 8) & 1);
    check("mclk", 32'(mclk0), (c >> 1) & 1);
`ifdef LINE_IN_LEVEL_EN
    check("level", 32'(level0), 32'(exp_level));
`endif
    if (sck0 && !p_sck) sck_rise++;
    if (lrck0 && !p_lrck) lrck_rise++;
    if (mclk0 && !p_mclk) mclk_rise++;
    if (valid0) pulses++;
    p_sck = sck0;
    p_lrck = lrck0;
    p_mclk = mclk0;
    // Codec model: slot b of frame f carries left bit 16-b (b=1..16),
    // right bit 32-b (b=17..31); slot 0 carries previous right LSB.
    b = c / 16;
    f = edges / 512;
    if (reset) audio_sdout = 1'b0;
    else if (b == 0) audio_sdout = (f == 0) ? 1'($urandom % 2) : fr[f-1][0];
    else if (b <= 16) audio_sdout = fl[f][16-b];
    else audio_sdout = fr[f][32-b];
  endtask

  task automatic clear_counts();
    sck_rise = 0;
    lrck_rise = 0;
    mclk_rise = 0;
    pulses = 0;
    p_sck = sck0;
    p_lrck = lrck0;
    p_mclk = mclk0;
  endtask

  task automatic randomize_frames();
    for (int i = 0; i < 16; i++) begin
      fl[i] = 16'($urandom);
      fr[i] = 16'($urandom);
    end
  endtask

  initial begin
    // Reset state
    randomize_frames();
    clear_counts();
    reset = 1'b1;
    repeat (4) tick();

    // Directed frames: reference pair, swap pair, boundary values, random rest
    fl[0] = 16'hA5C3; fr[0] = 16'h5A3C;
    fl[1] = 16'h1234; fr[1] = 16'hFEDC;
    fl[2] = 16'h8000; fr[2] = 16'h7FFF;
    fl[3] = 16'h7FFF; fr[3] = 16'h8000;
    fl[4] = 16'h0FFF; fr[4] = 16'h0000;
    fl[5] = 16'h0000; fr[5] = 16'hFFFF;
    fl[6] = 16'hF801; fr[6] = 16'h0800;
    reset = 1'b0;
    clear_counts();
    repeat (5120) tick();
    check("sck_rises", 32'(sck_rise), 32'd320);
    check("lrck_rises", 32'(lrck_rise), 32'd10);
    check("mclk_rises", 32'(mclk_rise), 32'd1280);
    check("pulses_5120", 32'(pulses), 32'd9);

    // Mid-frame reset at cnt~300 discards the partial frame
    reset = 1'b1;
    repeat (2) tick();
    randomize_frames();
    reset = 1'b0;
    repeat (300) tick();
    reset = 1'b1;
    repeat (3) tick();
    randomize_frames();
    reset = 1'b0;
    clear_counts();
    repeat (521 + 512 * 4) tick();
    check("pulses_after_reset", 32'(pulses), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
